// File: rtl/goldcrest_spi_master.sv
// SPI master: one word per transfer, MSB first, all four cpol/cpha modes, a programmable
// half-period divider, and optional chip-select hold between back-to-back transfers.
module goldcrest_spi_master #(
  parameter int NUM_CS = 3,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8,
  localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              cs_hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              spi_clk_o,
  output logic              spi_data_o,
  input  logic              spi_data_i,
  output logic [NUM_CS-1:0] spi_cs_o
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, DONE} state_t;

  state_t             state_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [DIV_W-1:0]   cnt_reg;
  logic [EW-1:0]      edge_cnt_reg;
  logic [DATA_W-1:0]  tx_sh_reg;
  logic [DATA_W-1:0]  rx_sh_reg;
  logic [DATA_W-1:0]  rx_data_reg;
  logic               cpha_reg;
  logic               hold_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               spi_clk_reg;
  logic               spi_data_reg;
  logic [NUM_CS-1:0]  spi_cs_reg;
  logic [NUM_CS-1:0]  cs_dec;

  // An out-of-range cs_sel decodes to all-high, so the transfer runs unselected.
  generate
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_dec[gi] = (cs_sel != CSW'(gi));
    end
  endgenerate

  logic tick, edge_now, edge_lead, edge_last, do_sample, do_drive;

  always_comb begin
    tick      = (cnt_reg == div_reg);
    edge_now  = tick && ((state_reg == LEAD) ||
                         ((state_reg == SHIFT) && (edge_cnt_reg != LAST_EDGE)));
    edge_lead = (state_reg == LEAD) || !edge_cnt_reg[0];
    edge_last = (state_reg == SHIFT) && (edge_cnt_reg == LAST_EDGE - EW'(1));
    do_sample = edge_now && (edge_lead != cpha_reg);
    // The final trailing edge in mode 0 has no next bit, so MOSI keeps the LSB.
    do_drive  = edge_now && (edge_lead == cpha_reg) && !edge_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      div_reg      <= '0;
      cnt_reg      <= '0;
      edge_cnt_reg <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      rx_data_reg  <= '0;
      cpha_reg     <= 1'b0;
      hold_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      spi_clk_reg  <= 1'b0;
      spi_data_reg <= 1'b0;
      spi_cs_reg   <= '1;
    end else begin
      done_reg <= 1'b0;
      if (do_sample) rx_sh_reg <= {rx_sh_reg[DATA_W-2:0], spi_data_i};
      if (do_drive) begin
        spi_data_reg <= tx_sh_reg[DATA_W-1];
        tx_sh_reg    <= {tx_sh_reg[DATA_W-2:0], 1'b0};
      end
      if (edge_now) spi_clk_reg <= ~spi_clk_reg;

      unique case (state_reg)
        IDLE: begin
          spi_clk_reg <= cpol;
          if (start) begin
            state_reg  <= LEAD;
            busy_reg   <= 1'b1;
            div_reg    <= clk_div;
            cnt_reg    <= '0;
            cpha_reg   <= cpha;
            hold_reg   <= cs_hold;
            // Releases any held select and asserts the new one in the same cycle.
            spi_cs_reg <= cs_dec;
            if (cpha) begin
              tx_sh_reg <= tx_data;
            end else begin
              spi_data_reg <= tx_data[DATA_W-1];
              tx_sh_reg    <= {tx_data[DATA_W-2:0], 1'b0};
            end
          end
        end
        LEAD: begin
          if (tick) begin
            cnt_reg      <= '0;
            edge_cnt_reg <= EW'(1);
            state_reg    <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
          end
        end
        SHIFT: begin
          if (tick) begin
            cnt_reg      <= '0;
            edge_cnt_reg <= edge_cnt_reg + EW'(1);
            if (edge_cnt_reg == LAST_EDGE) state_reg <= TRAIL;
          end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
          end
        end
        TRAIL: begin
          if (tick) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
          end
        end
        DONE: begin
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          rx_data_reg <= rx_sh_reg;
          spi_clk_reg <= cpol;
          if (!hold_reg) spi_cs_reg <= '1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign rx_data    = rx_data_reg;
  assign spi_clk_o  = spi_clk_reg;
  assign spi_data_o = spi_data_reg;
  assign spi_cs_o   = spi_cs_reg;

endmodule
